// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, FUNC3 codes and access legality check for the load/store unit.
package lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ill;
    logic mis;
    ill = we ? (f3 > F3_W) : (f3 == 3'd3 || f3[2:1] == 2'b11);
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3 == F3_W && a != 2'b00);
    return ill || mis;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core-side request/response bundle and data-bus bundle of the load/store unit.
interface lsu_core_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;
  modport master(output req_valid, req_write, func3, addr, wdata, input stall, done, rdata, misalign, bus_err);
  modport slave(input req_valid, req_write, func3, addr, wdata, output stall, done, rdata, misalign, bus_err);
endinterface

interface lsu_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, we, addr, be, wdata, input ready, rvalid, rdata);
  modport slave(input req, we, addr, be, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-enable/store-lane steering and load lane extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rext
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rword[{addr, 3'b000} +: 8];
    h = addr[1] ? rword[31:16] : rword[15:0];
    be = func3[1] ? 4'b1111 : func3[0] ? 4'b0011 << addr : 4'b0001 << addr;
    wlanes = func3[1] ? wdata : func3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    rext = func3 == F3_W  ? rword :
           func3 == F3_H  ? {{16{h[15]}}, h} :
           func3 == F3_HU ? {16'b0, h} :
           func3 == F3_B  ? {{24{b[7]}}, b} : {24'b0, b};
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store engine between core and data bus, with stall,
// misalignment detection and bus timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         CLK,
  input logic         RESET,
  lsu_core_if.slave   core,
  lsu_bus_if.master   bus
);
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be;
  logic [31:0] wlanes, rext;
  logic        tmo, in_req;
  lsu_align u_align (
    .func3(f3_q), .addr(addr_q[1:0]), .wdata(wdata_q), .rword(bus.rdata),
    .be(be), .wlanes(wlanes), .rext(rext)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == S_REQ || state_q == S_WAIT) ? cnt_q + 8'd1 : 8'd0;
    we_d = we_q;
    f3_d = f3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d = mis_q;
    err_d = err_q;
    tmo = cnt_q == LAST;
    case (state_q)
      S_IDLE: if (core.req_valid) begin
        we_d = core.req_write;
        f3_d = core.func3;
        addr_d = core.addr;
        wdata_d = core.wdata;
        mis_d = access_bad(core.req_write, core.func3, core.addr[1:0]);
        err_d = 1'b0;
        rdata_d = 32'd0;
        state_d = mis_d ? S_DONE : S_REQ;
      end
      S_REQ: if (bus.ready) begin
        cnt_d = 8'd0;
        state_d = (we_q || bus.rvalid) ? S_DONE : S_WAIT;
        rdata_d = (!we_q && bus.rvalid) ? rext : 32'd0;
      end else if (tmo) begin
        state_d = S_DONE;
        err_d = 1'b1;
      end
      S_WAIT: if (bus.rvalid) begin
        state_d = S_DONE;
        rdata_d = rext;
      end else if (tmo) begin
        state_d = S_DONE;
        err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q <= 8'd0;
      we_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end
  // Bus outputs are only driven while a request is outstanding; zero otherwise.
  assign in_req = state_q == S_REQ;
  assign bus.req = in_req;
  assign bus.we = in_req & we_q;
  assign bus.addr = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.be = in_req ? be : 4'd0;
  assign bus.wdata = in_req ? wlanes : 32'd0;
  assign core.stall = (state_q == S_IDLE && core.req_valid) || in_req || state_q == S_WAIT;
  assign core.done = state_q == S_DONE;
  assign core.rdata = core.done ? rdata_q : 32'd0;
  assign core.misalign = core.done & mis_q;
  assign core.bus_err = core.done & err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized transactions checked cycle by cycle against a transaction-level model.
module tb_load_store_unit;
  localparam int T = 255;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;
  lsu_core_if core();
  lsu_bus_if bus();
  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (.CLK(CLK), .RESET(RESET), .core(core), .bus(bus));

  int total = 0;
  int bad = 0;
  bit chk = 0;
  int cyc_n = 0;
  int done_at = 0;
  bit saw_req = 0;
  logic e_stall, e_done, e_mis, e_err, e_req, e_we;
  logic [31:0] e_rdata, e_addr, e_wd;
  logic [3:0] e_be;
  logic [3:0] last_be;
  logic [31:0] last_wd, last_addr, last_rdata;
  logic last_mis, last_err;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk) begin
      check("stall", 32'(core.stall), 32'(e_stall));
      check("done", 32'(core.done), 32'(e_done));
      check("misalign", 32'(core.misalign), 32'(e_mis));
      check("bus_err", 32'(core.bus_err), 32'(e_err));
      check("rdata", core.rdata, e_rdata);
      check("bus_req", 32'(bus.req), 32'(e_req));
      check("bus_we", 32'(bus.we), 32'(e_we));
      check("bus_addr", bus.addr, e_addr);
      check("bus_be", {28'd0, bus.be}, {28'd0, e_be});
      check("bus_wdata", bus.wdata, e_wd);
    end
    if (core.done) begin
      done_at = cyc_n;
      last_rdata = core.rdata;
      last_mis = core.misalign;
      last_err = core.bus_err;
    end
    if (bus.req) begin
      saw_req = 1;
      last_be = bus.be;
      last_wd = bus.wdata;
      last_addr = bus.addr;
    end
  end

  function automatic int sz(logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_bad(bit we, logic [2:0] f, logic [31:0] a);
    bit legal = we ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || (a % sz(f) != 0);
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f, logic [31:0] a);
    logic [31:0] x = ((32'd1 << sz(f)) - 32'd1) << (a % 4);
    return x[3:0];
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] f, logic [31:0] wd);
    if (sz(f) == 1) return (wd % 256) * 32'h01010101;
    if (sz(f) == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(logic [2:0] f, logic [31:0] a, logic [31:0] w);
    int n = sz(f);
    logic [31:0] v;
    if (n == 4) return w;
    v = (w >> (8 * ((a % 4) / n * n))) % (32'd1 << (8 * n));
    if ((f == 3'd0 || f == 3'd1) && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic exp_set(bit st, bit dn, bit ms, bit er, bit rq, bit w,
                         logic [31:0] rd, logic [31:0] ad, logic [31:0] wdv, logic [3:0] b);
    e_stall = st; e_done = dn; e_mis = ms; e_err = er; e_req = rq; e_we = w;
    e_rdata = rd; e_addr = ad; e_wd = wdv; e_be = b;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc_n++;
  endtask

  // One complete transaction: bus ready on REQ cycle rdl, read data on WAIT cycle vdl
  // (or together with ready when same=1). Delays >= T exercise the timeout.
  task automatic txn(bit we, logic [2:0] f, logic [31:0] a, logic [31:0] wd,
                     int rdl, int vdl, bit same, logic [31:0] word);
    bit bd = m_bad(we, f, a);
    bit err = 0;
    bit fin = 0;
    logic [31:0] res = 32'd0;
    cyc_n = 1; done_at = 0; saw_req = 0;
    core.req_valid = 1; core.req_write = we; core.func3 = f; core.addr = a; core.wdata = wd;
    bus.ready = 0; bus.rvalid = 1'($urandom); bus.rdata = $urandom;
    exp_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    if (!bd) begin
      for (int k = 0; !fin; k++) begin
        bus.ready = (k == rdl);
        bus.rvalid = (k == rdl && !we) ? same : 1'($urandom);
        bus.rdata = (k == rdl && same) ? word : $urandom;
        exp_set(1, 0, 0, 0, 1, we, 0, {a[31:2], 2'b00}, m_wd(f, wd), m_be(f, a));
        step();
        if (k == rdl) begin
          fin = 1;
          if (!we && same) res = m_ld(f, a, word);
        end else if (k == T - 1) begin
          fin = 1;
          err = 1;
        end
      end
      if (!we && !err && !same) begin
        fin = 0;
        for (int j = 0; !fin; j++) begin
          bus.ready = 1'($urandom);
          bus.rvalid = (j == vdl);
          bus.rdata = (j == vdl) ? word : $urandom;
          exp_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
          step();
          if (j == vdl) begin
            fin = 1;
            res = m_ld(f, a, word);
          end else if (j == T - 1) begin
            fin = 1;
            err = 1;
          end
        end
      end
    end
    core.req_valid = 1'($urandom); core.addr = $urandom; core.wdata = $urandom; core.func3 = 3'($urandom);
    bus.ready = 1'($urandom); bus.rvalid = 1'($urandom); bus.rdata = $urandom;
    exp_set(0, 1, bd, err, 0, 0, res, 0, 0, 0);
    step();
    core.req_valid = 0;
    bus.rvalid = 1'($urandom);
    exp_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    RESET = 1;
    core.req_valid = 0; core.req_write = 0; core.func3 = 0; core.addr = 0; core.wdata = 0;
    bus.ready = 0; bus.rvalid = 0; bus.rdata = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_stall", 32'(core.stall), 0);
    check("rst_done", 32'(core.done), 0);
    check("rst_bus_req", 32'(bus.req), 0);
    check("rst_rdata", core.rdata, 0);
    @(negedge CLK);
    RESET = 0;
    bus.rvalid = 1;
    exp_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk = 1;
    step();
    bus.rvalid = 0;
    step();

    txn(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    check("sw_done_cycle", done_at, 3);
    check("sw_addr", last_addr, 32'h100);
    check("sw_be", {28'd0, last_be}, 32'hF);
    check("sw_wdata", last_wd, 32'hDEADBEEF);
    check("sw_misalign", 32'(last_mis), 0);
    txn(1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 0, 0);
    check("sb_be", {28'd0, last_be}, 32'h8);
    check("sb_wdata", last_wd, 32'hA5A5A5A5);
    txn(0, 3'd0, 32'h102, 0, 0, 1, 0, 32'h0080FF00);
    check("lb_rdata", last_rdata, 32'hFFFFFF80);
    check("lb_done_cycle", done_at, 5);
    txn(0, 3'd4, 32'h102, 0, 0, 1, 0, 32'h0080FF00);
    check("lbu_rdata", last_rdata, 32'h00000080);
    txn(0, 3'd1, 32'h101, 0, 0, 0, 0, 0);
    check("lh_mis_done_cycle", done_at, 2);
    check("lh_misalign", 32'(last_mis), 1);
    check("lh_no_bus_req", 32'(saw_req), 0);
    txn(0, 3'd1, 32'h102, 0, 0, 0, 1, 32'h80010000);
    check("lh_same_cycle_rdata", last_rdata, 32'hFFFF8001);
    check("lh_same_cycle_done", done_at, 3);
    txn(0, 3'd7, 32'h100, 0, 0, 0, 0, 0);
    check("illegal_f3_misalign", 32'(last_mis), 1);
    txn(0, 3'd2, 32'h104, 0, 0, T + 10, 0, 32'h12345678);
    check("lw_wait_tmo_err", 32'(last_err), 1);
    check("lw_wait_tmo_rdata", last_rdata, 0);
    check("lw_wait_tmo_cycle", done_at, T + 3);
    txn(1, 3'd2, 32'h108, 32'h1, T + 10, 0, 0, 0);
    check("sw_req_tmo_err", 32'(last_err), 1);
    check("sw_req_tmo_cycle", done_at, T + 2);

    for (int i = 0; i < 80; i++) begin
      logic [2:0] f = ($urandom % 6 == 0) ? 3'($urandom) : legal_f3[$urandom % 5];
      logic [31:0] a = $urandom;
      if ($urandom % 4 != 0) a = a - (a % sz(f));
      txn(1'($urandom), f, a, $urandom, int'($urandom % 4), int'($urandom % 4),
          ($urandom % 4) == 0, $urandom);
    end

    // Asynchronous reset in the middle of a read wait.
    chk = 0;
    core.req_valid = 1; core.req_write = 0; core.func3 = 3'd2; core.addr = 32'h200;
    bus.ready = 0; bus.rvalid = 0;
    step();
    bus.ready = 1;
    step();
    bus.ready = 0;
    step();
    check("wait_stall_before_rst", 32'(core.stall), 1);
    #2;
    RESET = 1;
    core.req_valid = 0;
    #1;
    check("rst_mid_stall", 32'(core.stall), 0);
    check("rst_mid_bus_req", 32'(bus.req), 0);
    check("rst_mid_done", 32'(core.done), 0);
    @(negedge CLK);
    RESET = 0;
    step();
    bus.rvalid = 1; bus.rdata = 32'hCAFEF00D;
    @(negedge CLK);
    check("post_rst_rvalid_stall", 32'(core.stall), 0);
    check("post_rst_rvalid_done", 32'(core.done), 0);
    step();
    bus.rvalid = 0;
    @(negedge CLK);
    check("post_rst_done_later", 32'(core.done), 0);
    check("post_rst_rdata", core.rdata, 0);
    exp_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk = 1;
    txn(0, 3'd5, 32'h302, 0, 1, 0, 0, 32'hBEEF1234);
    check("lhu_after_rst", last_rdata, 32'h0000BEEF);

    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
